// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell, one bit per clock, LSB first.
// Optional subtract mode enabled by defining SERIAL_ADD_SUB_EN (adds port sub).

module serial_add_fa (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));

endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-2:0] res;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             fa_s;
    logic             fa_co;
    logic             load;
    logic             last;
    logic [WIDTH-1:0] ld_b;
    logic             ld_c;
    logic [WIDTH-1:0] res_nxt;

    // Subtract is a + ~b + 1; cin is overridden.
`ifdef SERIAL_ADD_SUB_EN
    assign ld_b = sub ? ~b : b;
    assign ld_c = sub ? 1'b1 : cin;
`else
    assign ld_b = b;
    assign ld_c = cin;
`endif

    serial_add_fa u_fa (
        .x  (sh_a[0]),
        .y  (sh_b[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    assign last    = (cnt == CNT_W'(WIDTH - 1));
    assign res_nxt = {fa_s, res};

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_a  <= '0;
            sh_b  <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (load) begin
            sh_a  <= a;
            sh_b  <= ld_b;
            res   <= '0;
            carry <= ld_c;
            cnt   <= '0;
        end else if (state == RUN) begin
            sh_a  <= sh_a >> 1;
            sh_b  <= sh_b >> 1;
            res   <= res_nxt[WIDTH-1:1];
            carry <= fa_co;
            cnt   <= cnt + 1'b1;
            // Outputs only update once the full word is assembled.
            if (last) begin
                sum  <= res_nxt;
                cout <= fa_co;
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random checks for serial_add_ctrl at WIDTH=8 and WIDTH=16.
// Subtract vectors run only when SERIAL_ADD_SUB_EN is defined.

module tb_serial_add_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        cin;
    logic        sub;
    logic        busy;
    logic        done;
    logic [7:0]  sum;
    logic        cout;

    logic        start16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic        cin16;
    logic        sub16;
    logic        busy16;
    logic        done16;
    logic [15:0] sum16;
    logic        cout16;

    int checks;
    int passed;

    serial_add_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    serial_add_ctrl #(.WIDTH(16), .CNT_W(5)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start16),
        .a     (a16),
        .b     (b16),
        .cin   (cin16),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub16),
`endif
        .busy  (busy16),
        .done  (done16),
        .sum   (sum16),
        .cout  (cout16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one op on the 8-bit DUT; returns cycles from accept to done.
    task automatic run_op(
        input  logic [7:0] va,
        input  logic [7:0] vb,
        input  logic       vc,
        output int         lat
    );
        @(negedge clk);
        a     = va;
        b     = vb;
        cin   = vc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
            $display("FAIL reset: busy=%b done=%b sum=%h cout=%b want 0 0 00 0",
                     busy, done, sum, cout);
        end else begin
            passed++;
        end
    endtask

    task automatic test_basic;
        int bad;
        bad = 0;
        @(negedge clk);
        a     = 8'h5A;
        b     = 8'h3C;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = 8'hFF;
        b     = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            if (busy !== 1'b1 || done !== 1'b0 || sum !== 8'h00) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            $display("FAIL busy_window: %0d bad cycles want 0", bad);
        end else begin
            passed++;
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || sum !== 8'h96 || cout !== 1'b0) begin
            $display("FAIL basic_result: done=%b busy=%b sum=%h cout=%b want 1 0 96 0",
                     done, busy, sum, cout);
        end else begin
            passed++;
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || sum !== 8'h96) begin
            $display("FAIL done_pulse: done=%b busy=%b sum=%h want 0 0 96",
                     done, busy, sum);
        end else begin
            passed++;
        end
    endtask

    task automatic test_carry;
        int lat;
        run_op(8'hFF, 8'h01, 1'b0, lat);
        checks++;
        if (lat !== 9 || sum !== 8'h00 || cout !== 1'b1) begin
            $display("FAIL carry_ff_01: lat=%0d sum=%h cout=%b want 9 00 1",
                     lat, sum, cout);
        end else begin
            passed++;
        end
        run_op(8'hFF, 8'hFF, 1'b1, lat);
        checks++;
        if (lat !== 9 || sum !== 8'hFF || cout !== 1'b1) begin
            $display("FAIL carry_ff_ff: lat=%0d sum=%h cout=%b want 9 ff 1",
                     lat, sum, cout);
        end else begin
            passed++;
        end
    endtask

    task automatic test_back_to_back;
        int n;
        @(negedge clk);
        a     = 8'h5A;
        b     = 8'h3C;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        a = 8'h01;
        b = 8'h01;
        n = 1;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 9 || sum !== 8'h96 || cout !== 1'b0) begin
            $display("FAIL held_start_ignored: lat=%0d sum=%h want 9 96", n, sum);
        end else begin
            passed++;
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            $display("FAIL b2b_restart: busy=%b done=%b want 1 0", busy, done);
        end else begin
            passed++;
        end
        n = 1;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 9 || sum !== 8'h02 || cout !== 1'b0) begin
            $display("FAIL b2b_result: spacing=%0d sum=%h want 9 02", n, sum);
        end else begin
            passed++;
        end
    endtask

    task automatic test_async_reset;
        int lat;
        int seen;
        @(negedge clk);
        a     = 8'hF0;
        b     = 8'h0F;
        cin   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
            $display("FAIL async_reset: busy=%b done=%b sum=%h cout=%b want 0 0 00 0",
                     busy, done, sum, cout);
        end else begin
            passed++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        checks++;
        if (seen != 0) begin
            $display("FAIL aborted_no_done: %0d active cycles want 0", seen);
        end else begin
            passed++;
        end
        run_op(8'h12, 8'h34, 1'b1, lat);
        checks++;
        if (lat !== 9 || sum !== 8'h47 || cout !== 1'b0) begin
            $display("FAIL after_reset: lat=%0d sum=%h cout=%b want 9 47 0",
                     lat, sum, cout);
        end else begin
            passed++;
        end
    endtask

`ifdef SERIAL_ADD_SUB_EN
    task automatic test_sub;
        int lat;
        sub = 1'b1;
        run_op(8'h10, 8'h01, 1'b0, lat);
        checks++;
        if (lat !== 9 || sum !== 8'h0F || cout !== 1'b1) begin
            $display("FAIL sub_10_01: lat=%0d sum=%h cout=%b want 9 0f 1",
                     lat, sum, cout);
        end else begin
            passed++;
        end
        run_op(8'h01, 8'h02, 1'b1, lat);
        checks++;
        if (lat !== 9 || sum !== 8'hFF || cout !== 1'b0) begin
            $display("FAIL sub_01_02: lat=%0d sum=%h cout=%b want 9 ff 0",
                     lat, sum, cout);
        end else begin
            passed++;
        end
        sub = 1'b0;
    endtask
`endif

    task automatic test_random8(input int nops);
        logic [8:0] exp;
        int n;
        int bad_val;
        int bad_gap;
        bad_val = 0;
        bad_gap = 0;
        @(negedge clk);
        a     = 8'($urandom);
        b     = 8'($urandom);
        cin   = 1'($urandom);
        start = 1'b1;
        for (int k = 0; k < nops; k++) begin
            exp = {1'b0, a} + {1'b0, b} + {8'h00, cin};
            @(negedge clk);
            a   = 8'($urandom);
            b   = 8'($urandom);
            cin = 1'($urandom);
            n   = 1;
            while (!done && n < 40) begin
                @(negedge clk);
                n++;
            end
            if ({cout, sum} !== exp) begin
                if (bad_val < 4)
                    $display("FAIL rand8_value: op %0d got %h want %h",
                             k, {cout, sum}, exp);
                bad_val++;
            end
            if (n != 9) bad_gap++;
            if (k == nops - 1) start = 1'b0;
        end
        checks++;
        if (bad_val != 0) begin
            $display("FAIL rand8: %0d wrong results want 0", bad_val);
        end else begin
            passed++;
        end
        checks++;
        if (bad_gap != 0) begin
            $display("FAIL rand8_spacing: %0d gaps not 9 want 0", bad_gap);
        end else begin
            passed++;
        end
        @(negedge clk);
    endtask

    task automatic test_random16(input int nops);
        logic [16:0] exp;
        int n;
        int bad_val;
        int bad_gap;
        bad_val = 0;
        bad_gap = 0;
        @(negedge clk);
        a16     = 16'($urandom);
        b16     = 16'($urandom);
        cin16   = 1'($urandom);
        start16 = 1'b1;
        for (int k = 0; k < nops; k++) begin
            exp = {1'b0, a16} + {1'b0, b16} + {16'h0000, cin16};
            @(negedge clk);
            a16   = 16'($urandom);
            b16   = 16'($urandom);
            cin16 = 1'($urandom);
            n     = 1;
            while (!done16 && n < 60) begin
                @(negedge clk);
                n++;
            end
            if ({cout16, sum16} !== exp) begin
                if (bad_val < 4)
                    $display("FAIL rand16_value: op %0d got %h want %h",
                             k, {cout16, sum16}, exp);
                bad_val++;
            end
            if (n != 17) bad_gap++;
            if (k == nops - 1) start16 = 1'b0;
        end
        checks++;
        if (bad_val != 0) begin
            $display("FAIL rand16: %0d wrong results want 0", bad_val);
        end else begin
            passed++;
        end
        checks++;
        if (bad_gap != 0) begin
            $display("FAIL rand16_spacing: %0d gaps not 17 want 0", bad_gap);
        end else begin
            passed++;
        end
        @(negedge clk);
    endtask

    initial begin
        checks  = 0;
        passed  = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        cin     = 1'b0;
        sub     = 1'b0;
        start16 = 1'b0;
        a16     = '0;
        b16     = '0;
        cin16   = 1'b0;
        sub16   = 1'b0;
        #12;
        test_reset;
        @(negedge clk);
        rst_n = 1'b1;
        test_basic;
        test_carry;
        test_back_to_back;
        test_async_reset;
`ifdef SERIAL_ADD_SUB_EN
        test_sub;
`endif
        test_random8(1000);
        test_random16(1000);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
